// File: rtl/response_checker.sv
// Response checker: compares a circuit's observed output against a 16-entry truth table,
// tracking coverage, mismatches, first failing index and an inactivity timeout.
module response_checker #(
   parameter logic [15:0] TRUTH      = 16'h6996,
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        valid_i,
   input  logic        in_a_i,
   input  logic        in_b_i,
   input  logic        in_c_i,
   input  logic        in_d_i,
   input  logic        in_f_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic        timed_out_o,
   output logic [4:0]  err_count_o,
   output logic        err_flag_o,
   output logic [3:0]  first_err_o,
   output logic [15:0] coverage_o
);

   localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             pass_q, pass_d;
   logic             timed_out_q, timed_out_d;
   logic [4:0]       err_count_q, err_count_d;
   logic             err_flag_q, err_flag_d;
   logic [3:0]       first_err_q, first_err_d;
   logic [15:0]      coverage_q, coverage_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

   logic [3:0]  index;
   logic        mismatch;
   logic [15:0] cov_set;

   assign index    = {in_a_i, in_b_i, in_c_i, in_d_i};
   assign mismatch = (in_f_i != TRUTH[index]);
   assign cov_set  = coverage_q | (16'b1 << index);

   // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
   always_comb begin
      state_d     = state_q;
      pass_d      = pass_q;
      timed_out_d = timed_out_q;
      err_count_d = err_count_q;
      err_flag_d  = err_flag_q;
      first_err_d = first_err_q;
      coverage_d  = coverage_q;
      idle_cnt_d  = idle_cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d     = S_RUN;
               pass_d      = 1'b0;
               timed_out_d = 1'b0;
               err_count_d = '0;
               err_flag_d  = 1'b0;
               first_err_d = '0;
               coverage_d  = '0;
               idle_cnt_d  = '0;
            end
         end
         S_RUN: begin
            if (valid_i) begin
               coverage_d = cov_set;
               idle_cnt_d = '0;
               if (mismatch) begin
                  if (err_count_q != 5'd31) err_count_d = err_count_q + 5'd1;
                  if (!err_flag_q) begin
                     err_flag_d  = 1'b1;
                     first_err_d = index;
                  end
               end
               // Completion uses the count including this vector's own mismatch.
               if (cov_set == 16'hFFFF) begin
                  state_d     = S_DONE;
                  pass_d      = (err_count_d == 5'd0);
                  timed_out_d = 1'b0;
               end
            end else begin
               idle_cnt_d = idle_cnt_q + CNT_W'(1);
               if (idle_cnt_q == IDLE_LAST) begin
                  state_d     = S_DONE;
                  timed_out_d = 1'b1;
                  pass_d      = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         pass_q      <= 1'b0;
         timed_out_q <= 1'b0;
         err_count_q <= '0;
         err_flag_q  <= 1'b0;
         first_err_q <= '0;
         coverage_q  <= '0;
         idle_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pass_q      <= pass_d;
         timed_out_q <= timed_out_d;
         err_count_q <= err_count_d;
         err_flag_q  <= err_flag_d;
         first_err_q <= first_err_d;
         coverage_q  <= coverage_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   assign busy_o      = (state_q == S_RUN);
   assign done_o      = (state_q == S_DONE);
   assign pass_o      = pass_q;
   assign timed_out_o = timed_out_q;
   assign err_count_o = err_count_q;
   assign err_flag_o  = err_flag_q;
   assign first_err_o = first_err_q;
   assign coverage_o  = coverage_q;

endmodule

// File: tb/tb_response_checker.sv
// Directed bench for response_checker: all-pass, errors, timeout, saturation,
// mid-run reset, restart and ignored-input cases against hand-computed results.
module tb_response_checker;

   localparam logic [15:0] TRUTH = 16'h6996;

   logic        clk = 1'b0;
   logic        rst, start, valid, in_a, in_b, in_c, in_d, in_f;
   logic        busy, done, pass, timed_out, err_flag;
   logic [4:0]  err_count;
   logic [3:0]  first_err;
   logic [15:0] coverage;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   response_checker #(.TRUTH(16'h6996), .WAIT_LIMIT(255)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .valid_i     (valid),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_c_i      (in_c),
      .in_d_i      (in_d),
      .in_f_i      (in_f),
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .timed_out_o (timed_out),
      .err_count_o (err_count),
      .err_flag_o  (err_flag),
      .first_err_o (first_err),
      .coverage_o  (coverage)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic vec(input logic [3:0] idx, input logic bad);
      logic [15:0] t;
      t     = TRUTH;
      valid = 1'b1;
      {in_a, in_b, in_c, in_d} = idx;
      in_f  = t[idx] ^ bad;
      tick();
      valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_done"},      done,      0);
      check({tag, "_pass"},      pass,      0);
      check({tag, "_timed_out"}, timed_out, 0);
      check({tag, "_err_count"}, err_count, 0);
      check({tag, "_err_flag"},  err_flag,  0);
      check({tag, "_first_err"}, first_err, 0);
      check({tag, "_coverage"},  coverage,  16'h0000);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; valid = 1'b0;
      in_a = 1'b0; in_b = 1'b0; in_c = 1'b0; in_d = 1'b0; in_f = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_vals("reset");

      // Valid in IDLE is ignored
      vec(4'd0, 1'b1);
      check("idle_valid_cov",  coverage,  16'h0000);
      check("idle_valid_errs", err_count, 0);
      check("idle_valid_busy", busy,      0);

      // All-pass session
      pulse_start();
      check("pass_busy_after_start", busy, 1);
      for (int i = 0; i < 16; i++) begin
         vec(4'(i), 1'b0);
         if (i == 0)  check("pass_latency_cov", coverage, 16'h0001);
         if (i == 14) check("pass_not_done_at_15", done, 0);
      end
      check("pass_done",      done,      1);
      check("pass_busy",      busy,      0);
      check("pass_pass",      pass,      1);
      check("pass_err_count", err_count, 0);
      check("pass_coverage",  coverage,  16'hFFFF);
      check("pass_timed_out", timed_out, 0);

      // Valid in DONE is ignored; results hold
      vec(4'd5, 1'b1);
      tick();
      check("done_hold_done",  done,      1);
      check("done_hold_pass",  pass,      1);
      check("done_hold_errs",  err_count, 0);

      // Errors at indices 5 and 9
      pulse_start();
      for (int i = 0; i < 16; i++) vec(4'(i), (i == 5) || (i == 9));
      check("err_done",      done,      1);
      check("err_err_count", err_count, 2);
      check("err_err_flag",  err_flag,  1);
      check("err_first_err", first_err, 5);
      check("err_pass",      pass,      0);

      // Restart from DONE with a simultaneous (ignored) mismatching Valid
      start = 1'b1;
      vec(4'd7, 1'b1);
      start = 1'b0;
      check("restart_busy",      busy,      1);
      check("restart_done",      done,      0);
      check("restart_err_count", err_count, 0);
      check("restart_err_flag",  err_flag,  0);
      check("restart_coverage",  coverage,  16'h0000);

      // Start in RUN ignored, then timeout with index 4 never seen
      vec(4'd2, 1'b0);
      pulse_start();
      check("run_start_busy", busy,     1);
      check("run_start_cov",  coverage, 16'h0004);
      for (int i = 0; i < 16; i++) if (i != 4) vec(4'(i), 1'b0);
      for (int i = 0; i < 254; i++) tick();
      check("to_not_yet_done", done, 0);
      check("to_not_yet_busy", busy, 1);
      tick();
      check("to_done",      done,      1);
      check("to_timed_out", timed_out, 1);
      check("to_pass",      pass,      0);
      check("to_coverage",  coverage,  16'hFFEF);
      check("to_err_count", err_count, 0);

      // Saturation at 31
      pulse_start();
      for (int i = 0; i < 40; i++) begin
         vec(4'd3, 1'b1);
         if (i == 29) check("sat_count_30", err_count, 30);
      end
      check("sat_err_count", err_count, 31);
      check("sat_first_err", first_err, 3);
      check("sat_busy",      busy,      1);
      check("sat_coverage",  coverage,  16'h0008);

      // Reset out of RUN, then mid-run reset after 8 vectors
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pulse_start();
      for (int i = 0; i < 8; i++) vec(4'(i), 1'b0);
      check("mid_cov_before_rst", coverage, 16'h00FF);
      rst = 1'b1;
      start = 1'b1;
      valid = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; valid = 1'b0;
      check_reset_vals("midrst");
      pulse_start();
      for (int i = 0; i < 16; i++) vec(4'(15 - i), 1'b0);
      check("after_rst_done", done, 1);
      check("after_rst_pass", pass, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
